mem_access_requester: RTL and testbench
=======================================

MEM_ACCESS_REQUESTER -- requirements
Module: mem_access_requester

Interface
REQ-001 SHALL have parameter CNT_W, default 16, width of the saturating statistics counters.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-004 SHALL have port req_valid  input  1  pipeline requests a data access.
REQ-005 SHALL have port req_write  input  1  1 = store, 0 = load.
REQ-006 SHALL have port req_addr  input  32  byte address.
REQ-007 SHALL have port req_wdata  input  32  store data.
REQ-008 SHALL have port req_rd  input  5  destination register tag, returned with the response.
REQ-009 SHALL have port req_ready  output  1  block accepts a request this cycle.
REQ-010 SHALL have port mem_read  output  1  read strobe to the data memory system.
REQ-011 SHALL have port mem_write  output  1  write strobe to the data memory system.
REQ-012 SHALL have port word_address  output  10  word address, equal to req_addr[11:2].
REQ-013 SHALL have port data_in  output  32  store data to the memory system.
REQ-014 SHALL have port stall  input  1  memory system busy; valid in the same cycle as the strobes.
REQ-015 SHALL have port data_out  input  32  load data; valid when a strobe is high and stall is 0.
REQ-016 SHALL have port resp_valid  output  1  one-cycle completion pulse.
REQ-017 SHALL have port resp_data  output  32  load data; 0 for stores and errors.
REQ-018 SHALL have port resp_rd  output  5  tag of the completed request.
REQ-019 SHALL have port resp_err  output  1  access rejected: misaligned or out of range.
REQ-020 SHALL have port hold  output  1  pipeline freeze, high in ACCESS state.
REQ-021 SHALL have port stall_cycles  output  CNT_W  saturating count of cycles spent in ACCESS with stall=1.
REQ-022 SHALL have port access_count  output  CNT_W  saturating count of completed memory accesses.

Function
REQ-023 SHALL implement the FSM states IDLE, ACCESS and RESP.
REQ-024 IDLE SHALL drive req_ready=1; every other state SHALL drive req_ready=0.
REQ-025 In IDLE, when req_valid=1, the block SHALL latch addr, wdata, write and rd into internal registers.
REQ-026 An accepted request with req_addr[1:0]!=0 or req_addr[31:12]!=0 SHALL go to RESP with resp_err=1 and SHALL NOT assert any memory strobe.
REQ-027 Any other accepted request SHALL go to ACCESS on the next edge.
REQ-028 In ACCESS, mem_read SHALL equal !write and mem_write SHALL equal write; word_address and data_in SHALL come from the latched registers and SHALL stay stable until the state is left.
REQ-029 In ACCESS with stall=1, the block SHALL stay in ACCESS and increment stall_cycles.
REQ-030 In ACCESS with stall=0, the access SHALL complete: a load SHALL capture data_out into resp_data, and the FSM SHALL go to RESP.
REQ-031 Minimum latency from acceptance to resp_valid SHALL be 2 cycles (a hit), plus one cycle per stalled cycle.
REQ-032 RESP SHALL assert resp_valid=1 for exactly one cycle, then return to IDLE; a new request is accepted no earlier than the following cycle.
REQ-033 Memory strobes SHALL be 0 in IDLE and RESP; mem_read and mem_write SHALL never be high together.
REQ-034 resp_data, resp_rd and resp_err SHALL hold their values until the next RESP.
REQ-035 access_count SHALL increment on each ACCESS->RESP transition.
REQ-036 Both counters SHALL saturate at all-ones and SHALL NOT wrap.
REQ-037 req_valid and input changes SHALL be ignored outside IDLE.

Reset
REQ-038 rst=1 SHALL asynchronously force state IDLE, all registers and outputs to 0, and req_ready to 1.
REQ-039 A reset during ACCESS SHALL drop mem_read and mem_write immediately, without waiting for a clock edge, and SHALL produce no resp_valid for the aborted request.

Verification
REQ-040 Load hit: addr=0x10, rd=3, stall=0, data_out=0xDEADBEEF -> word_address=4 for 1 cycle, then resp_valid with data 0xDEADBEEF, rd=3, err=0; access_count=1.
REQ-041 Store miss: addr=0x20, wdata=0x12345678, stall=1 for 5 cycles -> mem_write and data_in stable for 6 cycles, stall_cycles=5, then one resp_valid with resp_data=0.
REQ-042 Misaligned load: addr=0x13 -> resp_valid with err=1 one cycle after acceptance; mem_read never asserts; counters unchanged.
REQ-043 Out-of-range: addr=0x1000 -> err=1, no strobe.
REQ-044 Reset mid-miss: rst pulsed in the 3rd stalled cycle -> strobes 0 before the next edge, no resp_valid, req_ready=1.
REQ-045 Saturation: CNT_W=4, 20 stalled cycles -> stall_cycles=15.

Source files
------------

// File: rtl/mem_access_requester.sv
// mem_access_requester
//   Turns single pipeline load/store requests into strobed accesses on a
//   word-addressed data memory. It waits out memory stalls and returns one
//   completion pulse per request. It also keeps saturating counters of stalled
//   cycles and of completed accesses.
//
//   Ports
//     clk, rst                 clock, asynchronous active-high reset
//     req_valid/req_write/req_addr/req_wdata/req_rd
//                              request from the pipeline (sampled in IDLE only)
//     req_ready                high while a request can be accepted
//     mem_read/mem_write       memory strobes (ACCESS state only)
//     word_address, data_in    latched word address and store data
//     stall, data_out          memory busy flag and load data
//     resp_valid               one-cycle completion pulse
//     resp_data/resp_rd/resp_err
//                              completion payload, held until the next completion
//     hold                     pipeline freeze while an access is in flight
//     stall_cycles             saturating count of stalled ACCESS cycles
//     access_count             saturating count of completed memory accesses
module mem_access_requester #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  input  logic             req_write,
  input  logic [31:0]      req_addr,
  input  logic [31:0]      req_wdata,
  input  logic [4:0]       req_rd,
  output logic             req_ready,
  output logic             mem_read,
  output logic             mem_write,
  output logic [9:0]       word_address,
  output logic [31:0]      data_in,
  input  logic             stall,
  input  logic [31:0]      data_out,
  output logic             resp_valid,
  output logic [31:0]      resp_data,
  output logic [4:0]       resp_rd,
  output logic             resp_err,
  output logic             hold,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] access_count
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [9:0]         waddr_q, waddr_d;
  logic [31:0]        wdata_q, wdata_d;
  logic               write_q, write_d;
  logic [4:0]         rd_q, rd_d;
  logic [31:0]        rdata_q, rdata_d;
  logic [4:0]         rrd_q, rrd_d;
  logic               rerr_q, rerr_d;
  logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]   acc_cnt_q, acc_cnt_d;
  logic               bad_addr;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (&v) return v;
    return v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  // Only the low 4 KiB is backed by memory, and accesses must be word aligned.
  assign bad_addr = (|req_addr[1:0]) | (|req_addr[31:12]);

  always_comb begin
    state_d     = state_q;
    waddr_d     = waddr_q;
    wdata_d     = wdata_q;
    write_d     = write_q;
    rd_d        = rd_q;
    rdata_d     = rdata_q;
    rrd_d       = rrd_q;
    rerr_d      = rerr_q;
    stall_cnt_d = stall_cnt_q;
    acc_cnt_d   = acc_cnt_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          waddr_d = req_addr[11:2];
          wdata_d = req_wdata;
          write_d = req_write;
          rd_d    = req_rd;
          if (bad_addr) begin
            // Rejected requests skip the memory entirely and report at once.
            state_d = RESP;
            rdata_d = 32'd0;
            rrd_d   = req_rd;
            rerr_d  = 1'b1;
          end else begin
            state_d = ACCESS;
          end
        end
      end
      ACCESS: begin
        if (stall) begin
          stall_cnt_d = sat_inc(stall_cnt_q);
        end else begin
          state_d   = RESP;
          acc_cnt_d = sat_inc(acc_cnt_q);
          rdata_d   = write_q ? 32'd0 : data_out;
          rrd_d     = rd_q;
          rerr_d    = 1'b0;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      waddr_q     <= '0;
      wdata_q     <= '0;
      write_q     <= 1'b0;
      rd_q        <= '0;
      rdata_q     <= '0;
      rrd_q       <= '0;
      rerr_q      <= 1'b0;
      stall_cnt_q <= '0;
      acc_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      waddr_q     <= waddr_d;
      wdata_q     <= wdata_d;
      write_q     <= write_d;
      rd_q        <= rd_d;
      rdata_q     <= rdata_d;
      rrd_q       <= rrd_d;
      rerr_q      <= rerr_d;
      stall_cnt_q <= stall_cnt_d;
      acc_cnt_q   <= acc_cnt_d;
    end
  end

  // Strobes decode straight from the state register, so an asynchronous reset
  // removes them immediately rather than at the next edge.
  assign req_ready    = (state_q == IDLE);
  assign hold         = (state_q == ACCESS);
  assign mem_read     = (state_q == ACCESS) && !write_q;
  assign mem_write    = (state_q == ACCESS) &&  write_q;
  assign word_address = waddr_q;
  assign data_in      = wdata_q;
  assign resp_valid   = (state_q == RESP);
  assign resp_data    = rdata_q;
  assign resp_rd      = rrd_q;
  assign resp_err     = rerr_q;
  assign stall_cycles = stall_cnt_q;
  assign access_count = acc_cnt_q;

endmodule

// File: tb/tb_mem_access_requester.sv
module tb_mem_access_requester;

  localparam int CNT_W = 4;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst;
  logic             req_valid, req_write;
  logic [31:0]      req_addr, req_wdata;
  logic [4:0]       req_rd;
  logic             req_ready, mem_read, mem_write;
  logic [9:0]       word_address;
  logic [31:0]      data_in;
  logic             stall;
  logic [31:0]      data_out;
  logic             resp_valid;
  logic [31:0]      resp_data;
  logic [4:0]       resp_rd;
  logic             resp_err, hold;
  logic [CNT_W-1:0] stall_cycles, access_count;

  mem_access_requester #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_rd(req_rd), .req_ready(req_ready),
    .mem_read(mem_read), .mem_write(mem_write), .word_address(word_address),
    .data_in(data_in), .stall(stall), .data_out(data_out),
    .resp_valid(resp_valid), .resp_data(resp_data), .resp_rd(resp_rd),
    .resp_err(resp_err), .hold(hold),
    .stall_cycles(stall_cycles), .access_count(access_count)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference counters: totals of stalled cycles and completed accesses, clipped.
  int m_stall = 0;
  int m_acc   = 0;

  typedef struct {
    logic [31:0] addr;
    logic        wr;
    logic [31:0] wdata;
    logic [4:0]  rd;
    int          nstall;
    logic [31:0] dout;
    logic        exp_err;
    logic [31:0] exp_data;
  } vec_t;

  function automatic int clip(input int v);
    return (v > CMAX) ? CMAX : v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Issues one request from IDLE (caller is at posedge+1) and follows it to the
  // IDLE cycle after its response, checking every cycle on the way.
  task automatic run_txn(input logic [31:0] a, input logic w, input logic [31:0] wd,
                         input logic [4:0] rd, input int ns, input logic [31:0] dout,
                         input logic e_err, input logic [31:0] e_data);
    int base;
    base = m_stall;
    chk("ready_idle", 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = wd; req_rd = rd;
    stall = 1'($urandom); data_out = $urandom;
    @(posedge clk); #1;
    if (!e_err) begin
      for (int i = 0; i <= ns; i++) begin
        req_valid = 1'b1; req_write = 1'($urandom); req_addr = $urandom;
        req_wdata = $urandom; req_rd = 5'($urandom);
        stall    = (i < ns);
        data_out = (i == ns) ? dout : $urandom;
        chk("acc_mem_read",  32'(mem_read),     32'(!w));
        chk("acc_mem_write", 32'(mem_write),    32'(w));
        chk("acc_word_addr", 32'(word_address), 32'(a[11:2]));
        chk("acc_data_in",   data_in,           wd);
        chk("acc_hold",      32'(hold),         32'd1);
        chk("acc_ready",     32'(req_ready),    32'd0);
        chk("acc_resp_vld",  32'(resp_valid),   32'd0);
        chk("acc_stall_cnt", 32'(stall_cycles), 32'(clip(base + i)));
        @(posedge clk); #1;
      end
      m_stall = clip(m_stall + ns);
      m_acc   = clip(m_acc + 1);
    end
    chk("resp_valid",     32'(resp_valid),   32'd1);
    chk("resp_data",      resp_data,         e_data);
    chk("resp_rd",        32'(resp_rd),      32'(rd));
    chk("resp_err",       32'(resp_err),     32'(e_err));
    chk("resp_strobes",   32'({mem_read, mem_write}), 32'd0);
    chk("resp_ready",     32'(req_ready),    32'd0);
    chk("resp_stall_cnt", 32'(stall_cycles), 32'(m_stall));
    chk("resp_acc_cnt",   32'(access_count), 32'(m_acc));
    // Requests presented during RESP must be ignored.
    req_valid = 1'b1; req_addr = $urandom; req_rd = 5'($urandom); stall = 1'($urandom);
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("post_resp_valid", 32'(resp_valid), 32'd0);
    chk("post_ready",      32'(req_ready),  32'd1);
    chk("post_data_held",  resp_data,       e_data);
    chk("post_rd_held",    32'(resp_rd),    32'(rd));
    chk("post_err_held",   32'(resp_err),   32'(e_err));
    chk("post_strobes",    32'({mem_read, mem_write}), 32'd0);
  endtask

  vec_t vecs[6];

  initial begin
    vecs[0] = '{32'h10,   1'b0, 32'h0,        5'd3,  0, 32'hDEADBEEF, 1'b0, 32'hDEADBEEF};
    vecs[1] = '{32'h20,   1'b1, 32'h12345678, 5'd7,  5, 32'hAAAA5555, 1'b0, 32'h0};
    vecs[2] = '{32'h13,   1'b0, 32'h0,        5'd9,  0, 32'h55555555, 1'b1, 32'h0};
    vecs[3] = '{32'h1000, 1'b0, 32'h0,        5'd1,  0, 32'h77777777, 1'b1, 32'h0};
    vecs[4] = '{32'hFFC,  1'b1, 32'hCAFEF00D, 5'd31, 1, 32'h11111111, 1'b0, 32'h0};
    vecs[5] = '{32'h0,    1'b0, 32'h0,        5'd0,  2, 32'h01234567, 1'b0, 32'h01234567};

    rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = '0;
    req_wdata = '0; req_rd = '0; stall = 1'b0; data_out = '0;
    #1;
    chk("rst_ready",   32'(req_ready),   32'd1);
    chk("rst_strobes", 32'({mem_read, mem_write}), 32'd0);
    chk("rst_resp",    32'({resp_valid, resp_err, hold}), 32'd0);
    chk("rst_data",    resp_data,         32'd0);
    chk("rst_rd",      32'(resp_rd),      32'd0);
    chk("rst_waddr",   32'(word_address), 32'd0);
    chk("rst_din",     data_in,           32'd0);
    chk("rst_counts",  32'({stall_cycles, access_count}), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    for (int k = 0; k < 6; k++)
      run_txn(vecs[k].addr, vecs[k].wr, vecs[k].wdata, vecs[k].rd, vecs[k].nstall,
              vecs[k].dout, vecs[k].exp_err, vecs[k].exp_data);

    // Long miss drives the stall counter into saturation.
    run_txn(32'h84, 1'b0, 32'h0, 5'd12, 20, 32'hBEEF0001, 1'b0, 32'hBEEF0001);
    chk("sat_stall_cycles", 32'(stall_cycles), 32'(CMAX));

    for (int k = 0; k < 40; k++) begin
      logic [31:0] a, wd, dout;
      logic        w, e;
      int          sel, ns;
      sel = int'($urandom_range(0, 9));
      a   = $urandom;
      if (sel < 6)      a = {20'd0, a[11:2], 2'b00};
      else if (sel < 8) a = {20'd0, a[11:2], 2'($urandom_range(1, 3))};
      else              a = {a[31:12] | 20'h1, a[11:0]};
      w    = 1'($urandom);
      wd   = $urandom;
      dout = $urandom;
      ns   = int'($urandom_range(0, 4));
      e    = (a % 4 != 0) || (a >= 32'h1000);
      run_txn(a, w, wd, 5'($urandom), ns, dout, e, (e || w) ? 32'd0 : dout);
    end

    // Reset in the third stalled cycle of a miss.
    req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h40; req_wdata = 32'h5A5A5A5A;
    req_rd = 5'd4; stall = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
    end
    chk("midmiss_strobe_before", 32'(mem_write), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("midmiss_strobes",  32'({mem_read, mem_write}), 32'd0);
    chk("midmiss_ready",    32'(req_ready),  32'd1);
    chk("midmiss_hold",     32'(hold),       32'd0);
    chk("midmiss_resp_vld", 32'(resp_valid), 32'd0);
    chk("midmiss_counts",   32'({stall_cycles, access_count}), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0; stall = 1'b0;
    m_stall = 0; m_acc = 0;
    for (int i = 0; i < 3; i++) begin
      chk("after_rst_no_resp", 32'(resp_valid), 32'd0);
      chk("after_rst_ready",   32'(req_ready),  32'd1);
      @(posedge clk); #1;
    end
    run_txn(32'h44, 1'b0, 32'h0, 5'd6, 1, 32'h600DF00D, 1'b0, 32'h600DF00D);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
